// File: rtl/lane_pkg.sv
// Shared definitions for the lane selector: command encodings and default lane geometry.
package lane_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'b00,
    MODE_ROTL  = 2'b01,
    MODE_ROTR  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  localparam int LANE_IDX_W = 4;
  localparam int LANE_COUNT = 16;

endpackage

// File: rtl/onehot_dec.sv
// Parametrised binary-to-one-hot decoder; indices at or beyond OUT_W decode to all-zero
// and drop the in-range flag.
module onehot_dec #(
  parameter int IDX_W = 4,
  parameter int OUT_W = 16
) (
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] onehot,
  output logic             in_range
);

  localparam logic [IDX_W:0] OUT_W_L = OUT_W[IDX_W:0];

  // Range test and decode
  always_comb begin
    in_range = ({1'b0, idx} < OUT_W_L);
    onehot   = {OUT_W{1'b0}};
    for (int i = 0; i < OUT_W; i++) begin
      if (in_range && (idx == IDX_W'(i))) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/onehot_lane_sel.sv
// Registered index-to-one-hot lane selector with load/rotate/clear commands and a
// valid/ready handshake on both sides (no skid buffer; full throughput).
module onehot_lane_sel
  import lane_pkg::*;
#(
  parameter int IDX_W = LANE_IDX_W,
  parameter int OUT_W = LANE_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_W - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [OUT_W-1:0] ZERO_OH  = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0] LANE0_OH = {{(OUT_W-1){1'b0}}, 1'b1};

  if ((OUT_W > (2 ** IDX_W)) || (OUT_W < 2)) begin : g_bad_geometry
    $fatal(1, "onehot_lane_sel: OUT_W must satisfy 2 <= OUT_W <= 2**IDX_W");
  end

  logic [OUT_W-1:0] cur_r;
  logic [IDX_W-1:0] cur_idx_r;
  logic             out_valid_r;
  logic [OUT_W-1:0] out_onehot_r;
  logic [IDX_W-1:0] out_idx_r;
  logic             out_err_r;

  logic [IDX_W-1:0] dec_idx_s;
  logic [OUT_W-1:0] dec_onehot_s;
  logic             dec_in_range_s;
  logic             want_sel_s;
  logic             rot_err_s;
  logic             nxt_err_s;
  logic [OUT_W-1:0] nxt_cur_s;
  logic [IDX_W-1:0] nxt_idx_s;
  logic             accept_s;

  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  // Candidate index per command; rotating an empty selection is an error, not a reload
  always_comb begin
    dec_idx_s  = in_idx;
    want_sel_s = 1'b0;
    rot_err_s  = 1'b0;
    case (in_mode)
      MODE_LOAD: begin
        dec_idx_s  = in_idx;
        want_sel_s = 1'b1;
      end
      MODE_ROTL: begin
        if (cur_r == ZERO_OH) begin
          dec_idx_s = cur_idx_r;
          rot_err_s = 1'b1;
        end else begin
          dec_idx_s  = (cur_idx_r == LAST_IDX) ? ZERO_IDX : cur_idx_r + IDX_W'(1);
          want_sel_s = 1'b1;
        end
      end
      MODE_ROTR: begin
        if (cur_r == ZERO_OH) begin
          dec_idx_s = cur_idx_r;
          rot_err_s = 1'b1;
        end else begin
          dec_idx_s  = (cur_idx_r == ZERO_IDX) ? LAST_IDX : cur_idx_r - IDX_W'(1);
          want_sel_s = 1'b1;
        end
      end
      MODE_CLEAR: begin
        dec_idx_s  = in_idx;
        want_sel_s = 1'b0;
      end
      default: begin
        dec_idx_s  = in_idx;
        want_sel_s = 1'b0;
      end
    endcase
  end

  onehot_dec #(
    .IDX_W (IDX_W),
    .OUT_W (OUT_W)
  ) u_dec (
    .idx      (dec_idx_s),
    .onehot   (dec_onehot_s),
    .in_range (dec_in_range_s)
  );

  // Resolve the post-command selection; an out-of-range load leaves no lane selected
  always_comb begin
    nxt_err_s = rot_err_s || (want_sel_s && !dec_in_range_s);
    if (want_sel_s && dec_in_range_s) begin
      nxt_cur_s = dec_onehot_s;
      nxt_idx_s = dec_idx_s;
    end else begin
      nxt_cur_s = ZERO_OH;
      nxt_idx_s = ZERO_IDX;
    end
  end

  // Selection state and output register; everything freezes while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r        <= LANE0_OH;
      cur_idx_r    <= ZERO_IDX;
      out_valid_r  <= 1'b0;
      out_onehot_r <= ZERO_OH;
      out_idx_r    <= ZERO_IDX;
      out_err_r    <= 1'b0;
    end else if (accept_s) begin
      cur_r        <= nxt_cur_s;
      cur_idx_r    <= nxt_idx_s;
      out_valid_r  <= 1'b1;
      out_onehot_r <= nxt_cur_s;
      out_idx_r    <= nxt_idx_s;
      out_err_r    <= nxt_err_s;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_onehot = out_onehot_r;
  assign out_idx    = out_idx_r;
  assign out_err    = out_err_r;

endmodule

// File: tb/tb_onehot_lane_sel.sv
// Self-checking bench: a 16-lane and a 12-lane selector share one command stream and are
// compared against directed vectors and a lane-number reference model.
module tb_onehot_lane_sel;
  import lane_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_mode;
  logic [3:0]  in_idx;
  logic        out_ready;

  logic        in_ready16, out_valid16, out_err16;
  logic [15:0] out_onehot16;
  logic [3:0]  out_idx16;
  logic        in_ready12, out_valid12, out_err12;
  logic [11:0] out_onehot12;
  logic [3:0]  out_idx12;

  int checks = 0;
  int errors = 0;

  // reference model: selected lane number per DUT, -1 meaning no selection
  int          m_lane [2];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_oh  [2];
  int          exp_idx [2];
  bit          exp_err [2];

  typedef struct {
    bit          v;
    logic [1:0]  mode;
    logic [3:0]  idx;
    bit          e_valid;
    logic [15:0] e_oh16;
    logic [3:0]  e_idx16;
    bit          e_err16;
    logic [11:0] e_oh12;
    logic [3:0]  e_idx12;
    bit          e_err12;
  } vec_t;

  vec_t tbl [14];

  always #5 clk = ~clk;

  onehot_lane_sel #(.IDX_W(4), .OUT_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_mode(in_mode), .in_idx(in_idx), .out_valid(out_valid16),
    .out_ready(out_ready), .out_onehot(out_onehot16), .out_idx(out_idx16),
    .out_err(out_err16)
  );

  onehot_lane_sel #(.IDX_W(4), .OUT_W(12)) u_dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
    .in_mode(in_mode), .in_idx(in_idx), .out_valid(out_valid12),
    .out_ready(out_ready), .out_onehot(out_onehot12), .out_idx(out_idx12),
    .out_err(out_err12)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lanes(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic void model_cmd(input int lane, input logic [1:0] mode, input int idx,
                                    input int w, output int nlane, output bit err);
    nlane = -1;
    err   = 1'b0;
    case (mode)
      2'b00: begin
        if (idx < w) nlane = idx;
        else err = 1'b1;
      end
      2'b01: begin
        if (lane < 0) err = 1'b1;
        else nlane = (lane + 1) % w;
      end
      2'b10: begin
        if (lane < 0) err = 1'b1;
        else nlane = (lane + w - 1) % w;
      end
      default: nlane = -1;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [1:0] mode,
                            input logic [3:0] idx, input bit ordy);
    bit acc;
    int nl;
    bit e;
    acc = v && (!exp_valid || ordy);
    if (r) begin
      exp_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_lane[d] = 0; exp_oh[d] = 32'd0; exp_idx[d] = 0; exp_err[d] = 1'b0;
      end
    end else if (acc) begin
      exp_valid = 1'b1;
      for (int d = 0; d < 2; d++) begin
        model_cmd(m_lane[d], mode, int'(idx), lanes(d), nl, e);
        m_lane[d]  = nl;
        exp_oh[d]  = (nl >= 0) ? (32'd1 << nl) : 32'd0;
        exp_idx[d] = (nl >= 0) ? nl : 0;
        exp_err[d] = e;
      end
    end else if (ordy) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [1:0] mode,
                       input logic [3:0] idx, input bit ordy);
    rst = r; in_valid = v; in_mode = mode; in_idx = idx; out_ready = ordy;
    #1;
    if (!r) begin
      chk("in_ready16", 32'(in_ready16), 32'(!exp_valid || ordy));
      chk("in_ready12", 32'(in_ready12), 32'(!exp_valid || ordy));
    end
    @(posedge clk);
    model_step(r, v, mode, idx, ordy);
    #1;
    chk("out_valid16",  32'(out_valid16),  32'(exp_valid));
    chk("out_onehot16", 32'(out_onehot16), exp_oh[0]);
    chk("out_idx16",    32'(out_idx16),    32'(exp_idx[0]));
    chk("out_err16",    32'(out_err16),    32'(exp_err[0]));
    chk("out_valid12",  32'(out_valid12),  32'(exp_valid));
    chk("out_onehot12", 32'(out_onehot12), exp_oh[1]);
    chk("out_idx12",    32'(out_idx12),    32'(exp_idx[1]));
    chk("out_err12",    32'(out_err12),    32'(exp_err[1]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, MODE_LOAD,  4'd5,  1'b1, 16'h0020, 4'd5,  1'b0, 12'h020, 4'd5,  1'b0};
    tbl[1]  = '{1'b1, MODE_LOAD,  4'd15, 1'b1, 16'h8000, 4'd15, 1'b0, 12'h000, 4'd0,  1'b1};
    tbl[2]  = '{1'b1, MODE_ROTL,  4'd0,  1'b1, 16'h0001, 4'd0,  1'b0, 12'h000, 4'd0,  1'b1};
    tbl[3]  = '{1'b1, MODE_ROTR,  4'd0,  1'b1, 16'h8000, 4'd15, 1'b0, 12'h000, 4'd0,  1'b1};
    tbl[4]  = '{1'b1, MODE_LOAD,  4'd13, 1'b1, 16'h2000, 4'd13, 1'b0, 12'h000, 4'd0,  1'b1};
    tbl[5]  = '{1'b1, MODE_ROTL,  4'd9,  1'b1, 16'h4000, 4'd14, 1'b0, 12'h000, 4'd0,  1'b1};
    tbl[6]  = '{1'b1, MODE_LOAD,  4'd11, 1'b1, 16'h0800, 4'd11, 1'b0, 12'h800, 4'd11, 1'b0};
    tbl[7]  = '{1'b1, MODE_ROTL,  4'd0,  1'b1, 16'h1000, 4'd12, 1'b0, 12'h001, 4'd0,  1'b0};
    tbl[8]  = '{1'b1, MODE_ROTR,  4'd0,  1'b1, 16'h0800, 4'd11, 1'b0, 12'h800, 4'd11, 1'b0};
    tbl[9]  = '{1'b1, MODE_CLEAR, 4'd3,  1'b1, 16'h0000, 4'd0,  1'b0, 12'h000, 4'd0,  1'b0};
    tbl[10] = '{1'b1, MODE_ROTR,  4'd0,  1'b1, 16'h0000, 4'd0,  1'b1, 12'h000, 4'd0,  1'b1};
    tbl[11] = '{1'b1, MODE_LOAD,  4'd0,  1'b1, 16'h0001, 4'd0,  1'b0, 12'h001, 4'd0,  1'b0};
    tbl[12] = '{1'b1, MODE_ROTR,  4'd0,  1'b1, 16'h8000, 4'd15, 1'b0, 12'h800, 4'd11, 1'b0};
    tbl[13] = '{1'b0, MODE_LOAD,  4'd2,  1'b0, 16'h8000, 4'd15, 1'b0, 12'h800, 4'd11, 1'b0};

    cycle(1'b1, 1'b0, MODE_LOAD, 4'd0, 1'b1);
    cycle(1'b1, 1'b0, MODE_LOAD, 4'd0, 1'b1);
    chk("reset_valid", 32'(out_valid16), 32'd0);
    chk("reset_onehot", 32'(out_onehot16), 32'd0);

    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, tbl[i].v, tbl[i].mode, tbl[i].idx, 1'b1);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid16), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_oh16", i),  32'(out_onehot16), 32'(tbl[i].e_oh16));
      chk($sformatf("tbl%0d_idx16", i), 32'(out_idx16),    32'(tbl[i].e_idx16));
      chk($sformatf("tbl%0d_err16", i), 32'(out_err16),    32'(tbl[i].e_err16));
      chk($sformatf("tbl%0d_oh12", i),  32'(out_onehot12), 32'(tbl[i].e_oh12));
      chk($sformatf("tbl%0d_idx12", i), 32'(out_idx12),    32'(tbl[i].e_idx12));
      chk($sformatf("tbl%0d_err12", i), 32'(out_err12),    32'(tbl[i].e_err12));
    end

    // stream of rotations from lane 0
    cycle(1'b0, 1'b1, MODE_LOAD, 4'd0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1, MODE_ROTL, 4'd0, 1'b1);
      chk($sformatf("stream%0d_oh16", k), 32'(out_onehot16), 32'h2 << k);
      chk($sformatf("stream%0d_valid", k), 32'(out_valid16), 32'd1);
    end

    // consumer stall with a command held pending
    cycle(1'b0, 1'b1, MODE_LOAD, 4'd3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, MODE_LOAD, 4'd7, 1'b0);
      chk($sformatf("stall%0d_rdy", k), 32'(in_ready16), 32'd0);
      chk($sformatf("stall%0d_oh16", k), 32'(out_onehot16), 32'h0008);
    end
    cycle(1'b0, 1'b1, MODE_LOAD, 4'd7, 1'b1);
    chk("release_oh16", 32'(out_onehot16), 32'h0080);
    cycle(1'b0, 1'b1, MODE_LOAD, 4'd1, 1'b1);
    chk("next_oh16", 32'(out_onehot16), 32'h0002);
    cycle(1'b0, 1'b0, MODE_LOAD, 4'd9, 1'b1);
    chk("drain_valid", 32'(out_valid16), 32'd0);
    chk("drain_hold_oh16", 32'(out_onehot16), 32'h0002);

    // reset while a result is pending
    cycle(1'b0, 1'b1, MODE_CLEAR, 4'd0, 1'b1);
    cycle(1'b0, 1'b0, MODE_LOAD, 4'd0, 1'b0);
    chk("pending_valid", 32'(out_valid16), 32'd1);
    cycle(1'b1, 1'b0, MODE_LOAD, 4'd0, 1'b0);
    chk("rst_mid_valid", 32'(out_valid16), 32'd0);
    cycle(1'b0, 1'b1, MODE_ROTL, 4'd0, 1'b1);
    chk("rst_rotl_oh16", 32'(out_onehot16), 32'h0002);
    chk("rst_rotl_oh12", 32'(out_onehot12), 32'h0002);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
